// File: rtl/count_udl_mod.sv
// ---------------------------------------------------------------------------
// count_udl_mod
//
// Parametrised up/down counter with synchronous load and a runtime-programmable
// inclusive upper limit. The count always stays within 0..lim. At a bound it
// either wraps (SATURATE=0) or holds (SATURATE=1). A registered one-cycle pulse
// flags each attempted step past a bound. A combinational terminal count lets
// several instances be chained into wider counters or prescaler chains.
//
// Parameters
//   WIDTH     counter, load-data and limit width in bits (>= 2)
//   SATURATE  0 = wrap at bounds, 1 = hold at bounds
//   RESET_VAL value loaded into cnt by reset (must not exceed any lim in use)
//
// Ports
//   ck     in   clock; all state updates on the rising edge
//   reset  in   synchronous active-high reset, highest priority
//   en     in   count/load enable; en=0 holds cnt and clears the pulses
//   ud     in   direction, 1 = up, 0 = down
//   load   in   synchronous load of d, qualified by en
//   d      in   load value; clamped to lim
//   lim    in   inclusive upper bound, sampled every cycle
//   cnt    out  registered count
//   tc     out  terminal count: ud ? (cnt >= lim) : (cnt == 0)
//   tc_en  out  tc & en, enable for the next cascaded stage
//   ovf    out  registered pulse: up step attempted at the upper bound
//   udf    out  registered pulse: down step attempted at zero
// ---------------------------------------------------------------------------
module count_udl_mod #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             tc_en,
    output logic             ovf,
    output logic             udf
);

    // Operation selected for the coming edge (reset is handled in the register).
    typedef enum logic [1:0] {
        ActHold,
        ActLoad,
        ActUp,
        ActDown
    } act_e;

    act_e             act;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // Boundary conditions, all unsigned.
    logic             at_top;    // cnt at or above lim: an up step crosses the bound
    logic             above_lim; // cnt left above lim after lim was lowered
    logic             at_zero;
    logic [WIDTH-1:0] load_val;

    assign at_top    = (cnt_q >= lim);
    assign above_lim = (cnt_q > lim);
    assign at_zero   = (cnt_q == '0);
    assign load_val  = (d <= lim) ? d : lim;

    // Operation decode: load takes precedence over counting, both need en.
    always_comb begin
        act = ActHold;
        if (en) begin
            if (load) begin
                act = ActLoad;
            end else if (ud) begin
                act = ActUp;
            end else begin
                act = ActDown;
            end
        end
    end

    // Next-state logic. Bounds are checked before the +1/-1 so the arithmetic
    // never leaves 0..lim; with lim at all-ones this is a plain modulo counter.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        unique case (act)
            ActLoad: begin
                cnt_d = load_val;
            end
            ActUp: begin
                if (at_top) begin
                    ovf_d = 1'b1;
                    cnt_d = (SATURATE != 0) ? lim : '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            ActDown: begin
                if (above_lim) begin
                    // Resynchronise to the new, lower limit without a pulse.
                    cnt_d = lim;
                end else if (at_zero) begin
                    udf_d = 1'b1;
                    cnt_d = (SATURATE != 0) ? '0 : lim;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            ActHold: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State register; reset wins outright, so no pulse follows a reset edge.
    always_ff @(posedge ck) begin
        if (reset) begin
            cnt_q <= RESET_VAL;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Outputs. tc is combinational so a downstream stage sees the enable in
    // the same cycle the upstream stage sits at its terminal value.
    always_comb begin
        cnt   = cnt_q;
        ovf   = ovf_q;
        udf   = udf_q;
        tc    = ud ? at_top : at_zero;
        tc_en = tc & en;
    end

endmodule

// File: tb/tb_count_udl_mod.sv
module tb_count_udl_mod;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       ud = 1'b1;
    logic       load = 1'b0;
    logic [7:0] d = 8'd0;
    logic [7:0] lim = 8'd0;

    // Instance A: wrapping 8-bit counter.
    logic [7:0] a_cnt;
    logic       a_tc, a_tc_en, a_ovf, a_udf;
    // Instance B: saturating 8-bit counter.
    logic [7:0] b_cnt;
    logic       b_tc, b_tc_en, b_ovf, b_udf;
    // Cascade: two 4-bit stages, lim=15 each.
    logic [3:0] c0_cnt, c1_cnt;
    logic       c0_tc, c0_tc_en, c0_ovf, c0_udf;
    logic       c1_tc, c1_tc_en, c1_ovf, c1_udf;

    count_udl_mod #(.WIDTH(8), .SATURATE(0)) u_a (
        .ck(ck), .reset(reset), .en(en), .ud(ud), .load(load), .d(d), .lim(lim),
        .cnt(a_cnt), .tc(a_tc), .tc_en(a_tc_en), .ovf(a_ovf), .udf(a_udf)
    );

    count_udl_mod #(.WIDTH(8), .SATURATE(1)) u_b (
        .ck(ck), .reset(reset), .en(en), .ud(ud), .load(load), .d(d), .lim(lim),
        .cnt(b_cnt), .tc(b_tc), .tc_en(b_tc_en), .ovf(b_ovf), .udf(b_udf)
    );

    count_udl_mod #(.WIDTH(4), .SATURATE(0)) u_c0 (
        .ck(ck), .reset(reset), .en(en), .ud(ud), .load(1'b0), .d(4'd0), .lim(4'hf),
        .cnt(c0_cnt), .tc(c0_tc), .tc_en(c0_tc_en), .ovf(c0_ovf), .udf(c0_udf)
    );

    count_udl_mod #(.WIDTH(4), .SATURATE(0)) u_c1 (
        .ck(ck), .reset(reset), .en(c0_tc_en), .ud(ud), .load(1'b0), .d(4'd0), .lim(4'hf),
        .cnt(c1_cnt), .tc(c1_tc), .tc_en(c1_tc_en), .ovf(c1_ovf), .udf(c1_udf)
    );

    always #5 ck = ~ck;

    // Scoreboard entry: expected state after the edge following the push.
    typedef struct {
        int          sel;   // 0 = A, 1 = B, 2 = cascade
        logic [63:0] tag;
        logic [7:0]  cnt;
        logic        ovf;
        logic        udf;
        logic        ctc;   // compare tc/tc_en
        logic        tc;
        logic        tcen;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic drive(input int sel, input logic [63:0] tag,
                         input logic r, input logic e, input logic u, input logic l,
                         input logic [7:0] dv, input logic [7:0] lv,
                         input logic [7:0] ec, input logic eo, input logic eu,
                         input logic ctc, input logic etc);
        exp_t it;
        @(negedge ck);
        reset = r;
        en    = e;
        ud    = u;
        load  = l;
        d     = dv;
        lim   = lv;
        it.sel  = sel;
        it.tag  = tag;
        it.cnt  = ec;
        it.ovf  = eo;
        it.udf  = eu;
        it.ctc  = ctc;
        it.tc   = etc;
        it.tcen = etc & e;
        sb.push_back(it);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        exp_t       it;
        logic [7:0] ac;
        logic       ao, au, at, ate;
        bit         bad;
        @(posedge ck);
        #1;
        if (sb.size() != 0) begin
            it = sb.pop_front();
            case (it.sel)
                0: begin ac = a_cnt; ao = a_ovf; au = a_udf; at = a_tc; ate = a_tc_en; end
                1: begin ac = b_cnt; ao = b_ovf; au = b_udf; at = b_tc; ate = b_tc_en; end
                default: begin
                    ac = {c1_cnt, c0_cnt};
                    ao = c1_ovf;
                    au = c0_udf | c1_udf;
                    at = 1'b0;
                    ate = 1'b0;
                end
            endcase
            bad = (ac !== it.cnt) || (ao !== it.ovf) || (au !== it.udf);
            if (it.ctc && ((at !== it.tc) || (ate !== it.tcen))) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s @%0t: got cnt=%0d ovf=%0d udf=%0d tc=%0d tc_en=%0d, want cnt=%0d ovf=%0d udf=%0d tc=%0d tc_en=%0d",
                         it.tag, $time, ac, ao, au, at, ate,
                         it.cnt, it.ovf, it.udf, it.tc, it.tcen);
            end
        end
    end

    initial begin
        int c;

        // Up wrap, lim=9: 0..9 then 0,1; ovf with the return to 0, tc at 9.
        drive(0, "upwrap", 1, 0, 1, 0, 0, 9, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 11; k++) begin
            c = k % 10;
            drive(0, "upwrap", 0, 1, 1, 0, 0, 9, 8'(c), k == 10, 0, 1, c == 9);
        end

        // Down wrap: load 2, then 1,0,9(udf),8.
        drive(0, "dnload", 0, 1, 0, 1, 2, 9, 2, 0, 0, 1, 0);
        drive(0, "dnwrap", 0, 1, 0, 0, 0, 9, 1, 0, 0, 1, 0);
        drive(0, "dnwrap", 0, 1, 0, 0, 0, 9, 0, 0, 0, 1, 1);
        drive(0, "dnwrap", 0, 1, 0, 0, 0, 9, 9, 0, 1, 1, 0);
        drive(0, "dnwrap", 0, 1, 0, 0, 0, 9, 8, 0, 0, 1, 0);

        // Saturating instance, lim=5.
        drive(1, "satrst", 1, 0, 1, 0, 0, 5, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            c = (k < 5) ? k : 5;
            drive(1, "satup", 0, 1, 1, 0, 0, 5, 8'(c), k > 5, 0, 1, c >= 5);
        end
        for (int k = 1; k <= 7; k++) begin
            c = (k <= 5) ? (5 - k) : 0;
            drive(1, "satdn", 0, 1, 0, 0, 0, 5, 8'(c), 0, k > 5, 1, c == 0);
        end

        // Load clamp and runtime limit lowering.
        drive(0, "clamp", 0, 1, 1, 1, 200, 100, 100, 0, 0, 1, 1);
        drive(0, "limdn", 0, 1, 0, 0, 0, 50, 50, 0, 0, 1, 0);
        drive(0, "clamp", 0, 1, 1, 1, 200, 100, 100, 0, 0, 1, 1);
        drive(0, "limup", 0, 1, 1, 0, 0, 50, 0, 1, 0, 1, 0);

        // Priority: reset over load, en gates load, reset over a wrap.
        drive(0, "ld7", 0, 1, 1, 1, 7, 9, 7, 0, 0, 1, 0);
        drive(0, "rstpri", 1, 1, 1, 1, 8'h55, 9, 0, 0, 0, 1, 0);
        drive(0, "ld3", 0, 1, 1, 1, 3, 9, 3, 0, 0, 1, 0);
        drive(0, "enhold", 0, 0, 1, 1, 8, 9, 3, 0, 0, 1, 0);
        drive(0, "ld9", 0, 1, 1, 1, 9, 9, 9, 0, 0, 1, 1);
        drive(0, "rstwrap", 1, 1, 1, 0, 0, 9, 0, 0, 0, 1, 0);
        drive(0, "rstnext", 0, 0, 1, 0, 0, 9, 0, 0, 0, 1, 0);

        // Pulse lasts one cycle when followed by a hold.
        drive(0, "ld9", 0, 1, 1, 1, 9, 9, 9, 0, 0, 1, 1);
        drive(0, "wrap", 0, 1, 1, 0, 0, 9, 0, 1, 0, 1, 0);
        drive(0, "pclr", 0, 0, 1, 0, 0, 9, 0, 0, 0, 1, 0);

        // lim=0: every enabled step pulses.
        drive(0, "lim0up", 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        drive(0, "lim0up", 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        drive(0, "lim0dn", 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        // Full-range limit behaves as modulo 256.
        drive(0, "ld255", 0, 1, 1, 1, 255, 255, 255, 0, 0, 1, 1);
        drive(0, "mod256", 0, 1, 1, 0, 0, 255, 0, 1, 0, 1, 0);
        drive(0, "mod256", 0, 1, 1, 0, 0, 255, 1, 0, 0, 1, 0);

        // Cascade: combined value tracks cycle count mod 256.
        drive(2, "cascrst", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 300; k++) begin
            drive(2, "casc", 0, 1, 1, 0, 0, 0, 8'(k % 256), k == 256, 0, 0, 0);
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge ck);
            #2;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_udl_mod.md
Name: count_udl_mod

Overview:
- Parametrised bidirectional counter with synchronous load and a runtime-programmable upper limit.
- Counts within 0..lim, either wrapping or saturating at the bounds.
- Flags boundary crossings with registered overflow/underflow pulses.
- Provides a terminal-count output so several instances can be cascaded into wider counters or prescaler chains.
- Successor of the 8-bit up/down/load counter, used by timer and prescaler blocks.

Parameters:
WIDTH, 8, counter, load-data and limit width in bits (>=2)
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds
RESET_VAL, 0, value loaded into cnt by reset (must be <= every lim used)

Ports:
ck  input  1  clock, all state updates on rising edge
reset  input  1  synchronous reset, active-high, highest priority
en  input  1  count/load enable; en=0 holds all state except the pulse outputs
ud  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous load of d (qualified by en)
d  input  WIDTH  load value
lim  input  WIDTH  inclusive upper bound, sampled every cycle
cnt  output  WIDTH  registered count
tc  output  1  combinational terminal count: ud ? (cnt >= lim) : (cnt == 0)
tc_en  output  1  tc & en, cascade enable for the next stage
ovf  output  1  registered one-cycle pulse, up step attempted at upper bound
udf  output  1  registered one-cycle pulse, down step attempted at 0

Behaviour:
- Reset:
  - Synchronous; on posedge ck with reset=1: cnt <= RESET_VAL, ovf <= 0, udf <= 0.
  - Overrides en and load.
- Priority per edge: reset > (en & load) > (en & count) > hold.
- Load (en=1, load=1):
  - cnt <= d if d <= lim, else cnt <= lim (clamp).
  - ovf <= 0, udf <= 0.
  - ud is ignored.
- Count up (en=1, load=0, ud=1):
  - cnt < lim: cnt <= cnt+1, ovf <= 0.
  - cnt >= lim: ovf <= 1. SATURATE=0: cnt <= 0. SATURATE=1: cnt <= lim. This includes cnt > lim after lim is lowered at runtime.
  - udf <= 0.
- Count down (en=1, load=0, ud=0):
  - cnt > lim: cnt <= lim, no pulse (resynchronise after lim is lowered).
  - 0 < cnt <= lim: cnt <= cnt-1.
  - cnt == 0: udf <= 1. SATURATE=0: cnt <= lim. SATURATE=1: cnt stays 0.
  - ovf <= 0.
- Hold (en=0): cnt unchanged; ovf <= 0, udf <= 0. Pulses never last more than one cycle unless consecutive boundary steps occur.
- Pulse timing:
  - ovf/udf are high during the cycle after the edge that performed the boundary step.
  - Latency is 1 cycle, aligned with the new cnt value.
- tc and tc_en:
  - Purely combinational from cnt, lim, ud, en; no register delay.
  - Chaining rule: stage N+1 en = tc_en of stage N, all on the same ck, same ud.
- lim = 0:
  - cnt is forced to 0 by any enabled step.
  - Every enabled up step pulses ovf; every enabled down step pulses udf (both modes).
- lim changes: take effect on the next edge; no latching.
- Arithmetic:
  - All comparisons unsigned.
  - cnt+1 and cnt-1 never produce an out-of-range result, because boundaries are checked first.
  - At lim = 2^WIDTH-1 the behaviour equals a plain modulo-2^WIDTH counter.
- Reset mid-operation (e.g. during a load or boundary step) wins outright. There are no partial updates and no pulse in the following cycle.

Test Plan:
- WIDTH=8, SATURATE=0, lim=9, en=1, ud=1, from reset: 12 clocks.
  - Required: cnt 0..9 then 0,1.
  - ovf high exactly in the cycle cnt returns to 0.
  - tc high only while cnt=9.
- Down wrap, lim=9: load d=2, then ud=0 for 4 clocks.
  - Required: cnt 2,1,0,9,8.
  - udf pulse aligned with cnt=9.
- SATURATE=1, lim=5: up 8 clocks from 0.
  - Required: cnt sticks at 5; ovf high on each of the cycles after steps attempted at 5.
  - Then down 7 clocks: cnt reaches 0 and stays; udf pulses accordingly.
- Load clamp and runtime limit change:
  - Load d=200 with lim=100: required cnt=100.
  - Lower lim to 50 with cnt=100. Down step: required cnt=50, no udf. Up step instead: required cnt=0, ovf=1.
- Priority and reset:
  - reset=1 together with en=load=1, d=0x55: required cnt=RESET_VAL, no pulses.
  - en=0 with load=1: required cnt unchanged.
  - reset asserted the same edge cnt would wrap: required cnt=0, ovf=0 next cycle.
- Cascade: two WIDTH=4 instances, lim=15 each, second en = first tc_en, up for 300 clocks.
  - Required: combined value equals cycle count mod 256.
  - Second stage ovf fires once at 256.
